// File: rtl/rgb2gray_stream.sv
// Two-stage valid/ready RGB-to-gray converter with runtime mode select and sideband passthrough.
// Optional threshold output (thresh / out_bin) is built only when RGB2GRAY_THRESH_EN is defined.
`default_nettype none

module rgb2gray_stream #(
    parameter int CW  = 4,
    parameter int OW  = 4,
    parameter int SBW = 3
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3*CW-1:0]   in_rgb,
    input  logic [SBW-1:0]    in_sb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_gray,
    output logic [SBW-1:0]    out_sb
`ifdef RGB2GRAY_THRESH_EN
    ,
    input  logic [OW-1:0]     thresh,
    output logic              out_bin
`endif
);

    localparam int SW = CW + 2;
    localparam int WW = CW + 8;

    localparam logic [1:0] MODE_SUM   = 2'd0;
    localparam logic [1:0] MODE_LUMA  = 2'd1;
    localparam logic [1:0] MODE_MAX   = 2'd2;
    localparam logic [1:0] MODE_GREEN = 2'd3;

    function automatic logic [CW-1:0] max3(
        input logic [CW-1:0] a,
        input logic [CW-1:0] b,
        input logic [CW-1:0] c
    );
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    logic              adv_s;
    logic [CW-1:0]     ch_r_s;
    logic [CW-1:0]     ch_g_s;
    logic [CW-1:0]     ch_b_s;
    logic [SW-1:0]     sum_s;
    logic [WW-1:0]     wsum_s;
    logic [CW-1:0]     g_s;

    logic              s1_valid_d, s1_valid_q;
    logic [1:0]        s1_mode_d,  s1_mode_q;
    logic [SBW-1:0]    s1_sb_d,    s1_sb_q;
    logic [SW-1:0]     s1_sum_d,   s1_sum_q;
    logic [WW-1:0]     s1_wsum_d,  s1_wsum_q;
    logic [CW-1:0]     s1_max_d,   s1_max_q;
    logic [CW-1:0]     s1_g_d,     s1_g_q;

    logic              out_valid_d, out_valid_q;
    logic [OW-1:0]     out_gray_d,  out_gray_q;
    logic [SBW-1:0]    out_sb_d,    out_sb_q;
`ifdef RGB2GRAY_THRESH_EN
    logic              out_bin_d,   out_bin_q;
`endif

    // Low bits dropped by the shifts/truncation are intentionally discarded.
    logic              unused_bits_s;

    assign adv_s    = !out_valid_q || out_ready;
    assign in_ready = rst || adv_s;

    assign ch_r_s = in_rgb[3*CW-1 -: CW];
    assign ch_g_s = in_rgb[2*CW-1 -: CW];
    assign ch_b_s = in_rgb[CW-1:0];

    // Stage-1 arithmetic on the incoming pixel.
    always_comb begin
        sum_s  = {2'b00, ch_r_s} + {2'b00, ch_g_s} + {2'b00, ch_b_s};
        wsum_s = ({8'd0, ch_r_s} * {{CW{1'b0}}, 8'd77})
               + ({8'd0, ch_g_s} * {{CW{1'b0}}, 8'd150})
               + ({8'd0, ch_b_s} * {{CW{1'b0}}, 8'd29});
    end

    // Stage-1 next state: load on advance, data only for a valid pixel.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_sb_d    = s1_sb_q;
        s1_sum_d   = s1_sum_q;
        s1_wsum_d  = s1_wsum_q;
        s1_max_d   = s1_max_q;
        s1_g_d     = s1_g_q;
        if (adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d = mode;
                s1_sb_d   = in_sb;
                s1_sum_d  = sum_s;
                s1_wsum_d = wsum_s;
                s1_max_d  = max3(ch_r_s, ch_g_s, ch_b_s);
                s1_g_d    = ch_g_s;
            end else begin
                s1_mode_d = s1_mode_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Gray value selected by the mode captured with the pixel.
    always_comb begin
        case (s1_mode_q)
            MODE_SUM:   g_s = s1_sum_q[SW-1:2];
            MODE_LUMA:  g_s = s1_wsum_q[WW-1:8];
            MODE_MAX:   g_s = s1_max_q;
            MODE_GREEN: g_s = s1_g_q;
            default:    g_s = {CW{1'b0}};
        endcase
    end

    assign unused_bits_s = ^{1'b0, s1_sum_q[1:0], s1_wsum_q[7:0], g_s};

    // Stage-2 next state: bubbles clear the valid bit, data holds.
    always_comb begin
        out_valid_d = out_valid_q;
        out_gray_d  = out_gray_q;
        out_sb_d    = out_sb_q;
`ifdef RGB2GRAY_THRESH_EN
        out_bin_d   = out_bin_q;
`endif
        if (adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_gray_d = g_s[CW-1 -: OW];
                out_sb_d   = s1_sb_q;
`ifdef RGB2GRAY_THRESH_EN
                out_bin_d  = (g_s[CW-1 -: OW] >= thresh);
`endif
            end else begin
                out_sb_d = out_sb_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 2'd0;
            s1_sb_q     <= {SBW{1'b0}};
            s1_sum_q    <= {SW{1'b0}};
            s1_wsum_q   <= {WW{1'b0}};
            s1_max_q    <= {CW{1'b0}};
            s1_g_q      <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            out_gray_q  <= {OW{1'b0}};
            out_sb_q    <= {SBW{1'b0}};
`ifdef RGB2GRAY_THRESH_EN
            out_bin_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_sb_q     <= s1_sb_d;
            s1_sum_q    <= s1_sum_d;
            s1_wsum_q   <= s1_wsum_d;
            s1_max_q    <= s1_max_d;
            s1_g_q      <= s1_g_d;
            out_valid_q <= out_valid_d;
            out_gray_q  <= out_gray_d;
            out_sb_q    <= out_sb_d;
`ifdef RGB2GRAY_THRESH_EN
            out_bin_q   <= out_bin_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_gray  = out_gray_q;
    assign out_sb    = out_sb_q;
`ifdef RGB2GRAY_THRESH_EN
    assign out_bin   = out_bin_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rgb2gray_stream.sv
// Directed self-checking bench for rgb2gray_stream (CW=4 main instance, CW=8 extremes instance).
module tb_rgb2gray_stream;

    logic        pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_rgb;
    logic [2:0]  in_sb;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_gray;
    logic [2:0]  out_sb;

    logic [1:0]  mode8;
    logic        in8_valid;
    logic        in8_ready;
    logic [23:0] in8_rgb;
    logic [2:0]  in8_sb;
    logic        out8_valid;
    logic        out8_ready;
    logic [3:0]  out8_gray;
    logic [2:0]  out8_sb;

`ifdef RGB2GRAY_THRESH_EN
    logic [3:0]  thresh;
    logic        out_bin;
    logic        out8_bin;
`endif

    rgb2gray_stream #(.CW(4), .OW(4), .SBW(3)) dut (
        .pclk(pclk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb), .in_sb(in_sb),
        .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray), .out_sb(out_sb)
`ifdef RGB2GRAY_THRESH_EN
        , .thresh(thresh), .out_bin(out_bin)
`endif
    );

    rgb2gray_stream #(.CW(8), .OW(4), .SBW(3)) dut8 (
        .pclk(pclk), .rst(rst), .mode(mode8),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_rgb(in8_rgb), .in_sb(in8_sb),
        .out_valid(out8_valid), .out_ready(out8_ready), .out_gray(out8_gray), .out_sb(out8_sb)
`ifdef RGB2GRAY_THRESH_EN
        , .thresh(thresh), .out_bin(out8_bin)
`endif
    );

    typedef struct {
        logic [3:0] gray;
        logic [2:0] sb;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         accepted;
    bit         toggle_ready = 1'b0;
    logic [3:0] cur_gray;
    logic [2:0] cur_sb;
    bit         cur_lat;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: scoreboard work at the negedge, then advance past the posedge.
    task automatic step();
        exp_t e;
        @(negedge pclk);
        if (rst) begin
            check_eq("in_ready_rst", in_ready, 1);
        end else begin
            check_eq("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid) check_eq("out_expected", q.size() > 0, 1);
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                check_eq("gray", out_gray, e.gray);
                check_eq("sb", out_sb, e.sb);
`ifdef RGB2GRAY_THRESH_EN
                check_eq("bin", out_bin, e.gray >= 4'd8);
`endif
                if (e.lat) check_eq("latency", cyc - e.acc, 2);
            end
            if (in_valid && in_ready) begin
                e.gray = cur_gray;
                e.sb   = cur_sb;
                e.acc  = cyc;
                e.lat  = cur_lat;
                q.push_back(e);
                accepted = 1'b1;
            end
        end
        @(posedge pclk);
        cyc++;
        #1;
        if (toggle_ready) out_ready = ~out_ready;
    endtask

    task automatic send(input logic [11:0] rgb, input logic [1:0] md, input logic [2:0] sb,
                        input logic [3:0] exp_g, input bit lat);
        in_valid = 1'b1;
        in_rgb   = rgb;
        mode     = md;
        in_sb    = sb;
        cur_gray = exp_g;
        cur_sb   = sb;
        cur_lat  = lat;
        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) step();
        check_eq("accept_timeout", accepted, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && q.size() > 0; k++) step();
        check_eq("drain", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_rgb = 12'h000; in_sb = 3'd0; out_ready = 1'b1;
        mode8 = 2'd1; in8_valid = 1'b0; in8_rgb = 24'h000000; in8_sb = 3'd0; out8_ready = 1'b1;
`ifdef RGB2GRAY_THRESH_EN
        thresh = 4'd8;
`endif
        idle(2);
        rst = 1'b0;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_gray", out_gray, 0);
        check_eq("rst_out_sb", out_sb, 0);
        check_eq("rst_in_ready", in_ready, 1);
`ifdef RGB2GRAY_THRESH_EN
        check_eq("rst_out_bin", out_bin, 0);
`endif

        // Mode sweep on {8,4,2} and {3,9,5}, back to back.
        send(12'h842, 2'd0, 3'd1, 4'd3, 1'b1);
        send(12'h842, 2'd1, 3'd2, 4'd4, 1'b1);
        send(12'h842, 2'd2, 3'd3, 4'd8, 1'b1);
        send(12'h842, 2'd3, 3'd4, 4'd4, 1'b1);
        send(12'h395, 2'd0, 3'd5, 4'd4, 1'b1);
        send(12'h395, 2'd1, 3'd6, 4'd6, 1'b1);
        send(12'h395, 2'd2, 3'd7, 4'd9, 1'b1);
        send(12'h395, 2'd3, 3'd0, 4'd9, 1'b1);
        drain();

        // Extremes with bubbles between pixels.
        send(12'hFFF, 2'd0, 3'd1, 4'd11, 1'b1);
        idle(1);
        send(12'hFFF, 2'd1, 3'd2, 4'd15, 1'b1);
        send(12'hFFF, 2'd2, 3'd3, 4'd15, 1'b1);
        idle(2);
        send(12'h000, 2'd0, 3'd4, 4'd0, 1'b1);
        send(12'h000, 2'd1, 3'd5, 4'd0, 1'b1);
        send(12'h000, 2'd2, 3'd6, 4'd0, 1'b1);
        send(12'h000, 2'd3, 3'd7, 4'd0, 1'b1);
        drain();

        // Threshold boundary values via green-only mode.
        send(12'h070, 2'd3, 3'd1, 4'd7, 1'b1);
        send(12'h080, 2'd3, 3'd2, 4'd8, 1'b1);
        send(12'h0F0, 2'd3, 3'd3, 4'd15, 1'b1);
        drain();

        // CW=8 instance: full-scale luma must give 15 after two edges.
        in8_valid = 1'b1; in8_rgb = 24'hFFFFFF; in8_sb = 3'd5;
        step();
        in8_valid = 1'b0;
        check_eq("cw8_lat1_valid", out8_valid, 0);
        step();
        check_eq("cw8_valid", out8_valid, 1);
        check_eq("cw8_gray", out8_gray, 15);
        check_eq("cw8_sb", out8_sb, 5);

        // Backpressure: out_ready toggles every cycle while 10 pixels stream.
        toggle_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] gi;
            gi = 4'(i);
            send({4'h1, gi, 4'h0}, 2'd3, 3'(i), gi, 1'b0);
        end
        toggle_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with the pipeline full and stalled.
        out_ready = 1'b0;
        send(12'h842, 2'd2, 3'd1, 4'd8, 1'b0);
        send(12'h842, 2'd3, 3'd2, 4'd4, 1'b0);
        in_valid = 1'b1; in_rgb = 12'hFFF;
        step();
        in_valid = 1'b0;
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_out_gray", out_gray, 8);
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_gray", out_gray, 0);
        check_eq("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        idle(4);
        send(12'h395, 2'd2, 3'd6, 4'd9, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb2gray_stream.md
# rgb2gray_stream

Parametrised, pipelined colour-to-grayscale converter for the pixel stream in front of the face-detection datapath. Accepts one packed RGB pixel per cycle with a valid/ready handshake. Reduces it to a gray level using one of four runtime-selectable modes: sum/4, luma-weighted, max-channel, or green-only. Forwards a sideband word (sync/blank flags, coordinates) aligned with the pixel. Replaces the fixed 12-bit-to-4-bit combinational converter.

## Interface
- `CW`, 4, bits per colour channel; input pixel is `3*CW` bits.
- `OW`, 4, output gray width; legal range 1..`CW`.
- `SBW`, 3, sideband width carried alongside each pixel.
- `pclk`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  conversion mode; sampled with each accepted pixel.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  block can accept a pixel this cycle.
- `in_rgb`  in  3*CW  pixel packed as {R, G, B}, R in MSBs.
- `in_sb`  in  SBW  sideband, passed through unmodified.
- `out_valid`  out  1  output gray valid.
- `out_ready`  in  1  downstream accepts output.
- `out_gray`  out  OW  gray level.
- `out_sb`  out  SBW  sideband aligned to `out_gray`.
- `out_bin`  out  1  threshold result; present only with `RGB2GRAY_THRESH_EN`.
- `thresh`  in  OW  threshold level; present only with `RGB2GRAY_THRESH_EN`.

## Operation
- Transfer on either side occurs when valid and ready are both high on a `pclk` edge.
- Two-stage pipeline, S1 and S2, each with its own valid bit. S2 drives the outputs directly from registers.
- S1 registers the mode, sideband, and all intermediate results:
  - `sum = R+G+B`, CW+2 bits.
  - `wsum = 77*R + 150*G + 29*B`, CW+8 bits.
  - `max(R,G,B)`.
  - `G`.
- S2 selects a CW-bit gray value `g` by the registered mode:
  - 0: `sum >> 2`. Max input gives 3·(2^CW−1)/4, so no overflow.
  - 1: `wsum >> 8`. Max input gives exactly 2^CW−1.
  - 2: `max`.
  - 3: `G`.
- `out_gray = g[CW-1 -: OW]`, i.e. the MSBs, truncated with no rounding.
- All arithmetic is unsigned. No saturation is needed; widths above are exact.
- Global stall: `adv = !out_valid || out_ready`.
  - When `adv` is high, S1 moves to S2 and the input moves to S1. This includes bubbles: an invalid S1 clears the S2 valid bit.
  - When `adv` is low, both stages hold all registers.
- `in_ready = adv`. It is combinational from `out_valid` and `out_ready` only, and never from `in_valid`.
- A change of `mode` affects only pixels accepted after the change. Pixels already in flight keep the mode they captured.

## Timing
- Reset values: `out_valid=0`, `out_gray=0`, `out_sb=0`, `out_bin=0`, S1 valid=0. While `rst` is high, `in_ready` reads 1.
- Latency: a pixel accepted at edge N appears on the outputs after edge N+2, provided the path is not stalled.
- Throughput: 1 pixel/cycle with `out_ready` held high.
- Backpressure: while `out_valid && !out_ready`, the outputs hold stable and `in_ready=0`.
- When `out_ready` rises, the held output transfers and the pipeline advances on the same edge. No pixel is lost or duplicated.
- Pipeline full with `out_ready` low: 2 pixels are held, and nothing is accepted.
- Reset mid-stream: in-flight pixels are discarded and valids clear on the next edge. The first pixel accepted after reset is released with normal latency.
- `in_valid=0` cycles propagate as bubbles; `out_valid` falls for exactly those slots.

## Configuration
- `RGB2GRAY_THRESH_EN` defined:
  - Adds the `thresh` input and the `out_bin` output.
  - `out_bin = (out_gray >= thresh)`, computed from the S2 gray value and the `thresh` value sampled at the S1→S2 advance. It is registered in S2 with the same latency and stall behaviour as `out_gray`.
- `RGB2GRAY_THRESH_EN` undefined: both ports and the comparator logic are absent. All other behaviour is identical.

## Test plan
- Mode sweep, CW=4, OW=4, input {R=8,G=4,B=2}. Required `out_gray`: mode0 → 3, mode1 → 4 (1274>>8), mode2 → 8, mode3 → 4. Each appears 2 cycles after acceptance.
- Extremes, CW=4, input 0xFFF: mode0 → 11, mode1 → 15. Input 0x000: all modes → 0. Repeat with CW=8, OW=4, input 0xFFFFFF, mode1: `g=255`, so `out_gray=15`.
- Backpressure: stream 10 pixels with `out_ready` toggling every cycle. All 10 outputs arrive in order with the correct `out_sb`. `in_ready` is low exactly while `out_valid && !out_ready`.
- Mode change in flight: accept pixel A in mode0 and pixel B in mode1 on consecutive cycles. A is converted with mode0 and B with mode1.
- Reset with 2 pixels held (`out_ready=0`): assert `rst` for 1 cycle. The next cycle has `out_valid=0`, `out_gray=0`, `in_ready=1`. Both held pixels never appear.
- With `RGB2GRAY_THRESH_EN` and `thresh=8`: gray 7 → `out_bin=0`, gray 8 → 1, gray 15 → 1, with the same latency as `out_gray`.
